gpu_cmd_queue: RTL and testbench

// - Upstream feeder for the GPU command port. Buffers CPU-side command writes (2-bit opcode + 8-bit data) in a FIFO.
// - Replays each command to the GPU as a clean, edge-safe interrupt_enable pulse.
// - Opcode and data are held stable around the rising edge of the strobe, because the GPU samples on that edge.
// - Sits between the CPU bus decode and the gpu module's interrupt_in/data_in/interrupt_enable inputs.

---
 rtl/gpu_cmd_queue_if.sv | 30 +++
 rtl/gpu_cmd_queue.sv | 188 ++++++++++++++++++
 tb/tb_gpu_cmd_queue.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_cmd_queue_if.sv
// CPU-side command write port and GPU-side strobe port of gpu_cmd_queue.
// master = CPU decode / driver side, slave = the queue itself.
interface gpu_cmd_queue_if #(
  parameter int DEPTH = 16
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic            wr_en;
  logic [1:0]      wr_cmd;
  logic [7:0]      wr_data;
  logic            vblank;
  logic            full;
  logic            empty;
  logic [CNTW-1:0] count;
  logic            overflow;
  logic            busy;
  logic [1:0]      gpu_cmd;
  logic [7:0]      gpu_data;
  logic            gpu_int_en;

  modport master (
    output wr_en, wr_cmd, wr_data, vblank,
    input  full, empty, count, overflow, busy, gpu_cmd, gpu_data, gpu_int_en
  );

  modport slave (
    input  wr_en, wr_cmd, wr_data, vblank,
    output full, empty, count, overflow, busy, gpu_cmd, gpu_data, gpu_int_en
  );
endinterface

// File: rtl/gpu_cmd_queue.sv
// Buffers CPU command writes and replays each as a setup/strobe/gap framed gpu_int_en pulse; write-to-pop 1 edge,
// strobe rises 2 edges after the write; full drops writes and sets sticky overflow. Option GPU_CMDQ_VSYNC_SWAP_EN holds DISPLAY for vblank.
module gpu_cmd_queue #(
  parameter int DEPTH     = 16,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic           clk,
  input  logic           rst,
  gpu_cmd_queue_if.slave bus
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PW      = AW + 1;
  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CNT_MAX = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0] OP_DISPLAY = 2'b10;

  typedef struct packed {
    logic [1:0] cmd;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_GAP
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full_w;
  logic          empty_w;
  logic          push;
  logic          pop;
  logic          gate_ok;
  logic          launch_ok;
  logic          overflow_q;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          int_en_d;
  cmd_t          out_q;
  logic          int_en_q;

  // ---------------- FIFO ----------------
  assign head    = mem[rd_ptr[AW-1:0]];
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop on the same edge frees a slot, so a write into a full queue still lands.
  assign push    = bus.wr_en && (!full_w || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= cmd_t'{cmd: bus.wr_cmd, data: bus.wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.wr_en && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef GPU_CMDQ_VSYNC_SWAP_EN
  // A DISPLAY at the head blocks everything behind it until vertical blank.
  assign gate_ok = (head.cmd != OP_DISPLAY) || bus.vblank;
`else
  logic unused_vblank;
  logic [1:0] unused_op;
  assign gate_ok       = 1'b1;
  assign unused_vblank = bus.vblank;
  assign unused_op     = OP_DISPLAY;
`endif

  assign launch_ok = !empty_w && gate_ok;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (launch_ok) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = CW'(PULSE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CW'(GAP_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          if (launch_ok) begin
            state_d = ST_SETUP;
            cnt_d   = CW'(SETUP_CYC - 1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    pop      = 1'b0;
    int_en_d = 1'b0;
    if (launch_ok) begin
      pop = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (cnt_q == '0));
    end
    int_en_d = (state_d == ST_STROBE);
  end

  // Strobe and operands come straight from flops; operands move only on a pop edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      int_en_q <= 1'b0;
    end else begin
      if (pop) begin
        out_q <= head;
      end
      int_en_q <= int_en_d;
    end
  end

  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.count      = wr_ptr - rd_ptr;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.gpu_cmd    = out_q.cmd;
  assign bus.gpu_data   = out_q.data;
  assign bus.gpu_int_en = int_en_q;

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Directed bench for gpu_cmd_queue: reset, single/back-to-back replay, full/overflow, reset mid-pulse, DISPLAY gating.
module tb_gpu_cmd_queue;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;

  initial begin
    forever #5 clk = ~clk;
  end

  gpu_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  gpu_cmd_queue #(
    .DEPTH(DEPTH), .SETUP_CYC(1), .PULSE_CYC(2), .GAP_CYC(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] cmd, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_cmd  = cmd;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (!(bus.empty && !bus.busy) && n < max_cyc) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.empty && !bus.busy), 1);
  endtask

  // Strobe monitor: captures operands at each rising edge, pulse widths, rise times,
  // and operand changes while the strobe is high or just fell.
  logic [9:0] cap_q[$];
  int         rise_q[$];
  int         width_q[$];
  int         cyc       = 0;
  int         cur_w     = 0;
  int         stab_viol = 0;
  logic       prev_en   = 1'b0;
  logic [9:0] prev_bus  = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.gpu_int_en) begin
        if (!prev_en) begin
          cap_q.push_back({bus.gpu_cmd, bus.gpu_data});
          rise_q.push_back(cyc);
          cur_w = 0;
        end
        cur_w++;
      end else if (prev_en) begin
        width_q.push_back(cur_w);
      end
      if (({bus.gpu_cmd, bus.gpu_data} != prev_bus) && (bus.gpu_int_en || prev_en)) begin
        stab_viol++;
      end
      prev_en  = bus.gpu_int_en;
      prev_bus = {bus.gpu_cmd, bus.gpu_data};
    end
  end

  task automatic clear_mon();
    cap_q.delete();
    rise_q.delete();
    width_q.delete();
    stab_viol = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int peak;

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_cmd  = 2'b00;
    bus.wr_data = 8'h00;
    bus.vblank  = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_empty",    32'(bus.empty), 1);
    chk("rst_full",     32'(bus.full), 0);
    chk("rst_count",    32'(bus.count), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_busy",     32'(bus.busy), 0);
    chk("rst_int_en",   32'(bus.gpu_int_en), 0);
    chk("rst_cmd",      32'(bus.gpu_cmd), 0);
    chk("rst_data",     32'(bus.gpu_data), 0);
    rst = 1'b0;
    tick();

    // Single write: pop next edge, strobe high for edges k+2,k+3, low at k+4
    clear_mon();
    wr(2'b00, 8'h41);
    chk("t1_count_after_wr", 32'(bus.count), 1);
    chk("t1_empty_after_wr", 32'(bus.empty), 0);
    chk("t1_busy_after_wr",  32'(bus.busy), 0);
    tick();
    chk("t1_pop_busy",   32'(bus.busy), 1);
    chk("t1_pop_data",   32'(bus.gpu_data), 'h41);
    chk("t1_pop_cmd",    32'(bus.gpu_cmd), 0);
    chk("t1_pop_count",  32'(bus.count), 0);
    chk("t1_setup_int",  32'(bus.gpu_int_en), 0);
    tick();
    chk("t1_strobe0",    32'(bus.gpu_int_en), 1);
    tick();
    chk("t1_strobe1",    32'(bus.gpu_int_en), 1);
    tick();
    chk("t1_gap_int",    32'(bus.gpu_int_en), 0);
    chk("t1_gap_data",   32'(bus.gpu_data), 'h41);
    tick();
    chk("t1_idle_busy",  32'(bus.busy), 0);
    chk("t1_idle_data",  32'(bus.gpu_data), 'h41);
    chk("t1_width",      32'(width_q.size() > 0 ? width_q[0] : -1), 2);

    // Four back-to-back writes: 4-cycle period, peak occupancy 3
    clear_mon();
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_cmd  = 2'(i);
      bus.wr_data = 8'(8'h41 + i);
      tick();
      if (int'(bus.count) > peak) peak = int'(bus.count);
    end
    bus.wr_en = 1'b0;
    wait_idle("t2_drain", 60);
    chk("t2_peak",      32'(peak), 3);
    chk("t2_npulses",   32'(cap_q.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_q.size()) chk("t2_order", 32'(cap_q[i]), 32'(i * 256 + 'h41 + i));
      if (i < width_q.size()) chk("t2_width", 32'(width_q[i]), 2);
      if (i > 0 && i < rise_q.size()) chk("t2_period", 32'(rise_q[i] - rise_q[i-1]), 4);
    end
    chk("t2_stable", 32'(stab_viol), 0);
    chk("t2_empty",  32'(bus.empty), 1);

    // Fill to full with continuous writes; pops happen on edges 1,5,9,...,21.
    // Edge 20 reaches 16, edge 21 pops+writes, edge 22 write is dropped.
    clear_mon();
    for (int i = 0; i < 23; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_cmd  = 2'(i);
      bus.wr_data = 8'(128 + i);
      tick();
      if (i == 19) begin
        chk("t3_full_e19",  32'(bus.full), 0);
        chk("t3_count_e19", 32'(bus.count), 15);
      end
      if (i == 20) begin
        chk("t3_full_e20",  32'(bus.full), 1);
        chk("t3_count_e20", 32'(bus.count), 16);
        chk("t3_ovf_e20",   32'(bus.overflow), 0);
      end
      if (i == 21) begin
        chk("t3_full_pop_wr_count", 32'(bus.count), 16);
        chk("t3_full_pop_wr_ovf",   32'(bus.overflow), 0);
      end
      if (i == 22) begin
        chk("t3_drop_count", 32'(bus.count), 16);
        chk("t3_drop_ovf",   32'(bus.overflow), 1);
      end
    end
    bus.wr_en = 1'b0;
    wait_idle("t3_drain", 200);
    chk("t3_npulses", 32'(cap_q.size()), 22);
    for (int i = 0; i < 22; i++) begin
      if (i < cap_q.size()) chk("t3_order", 32'(cap_q[i]), 32'((i % 4) * 256 + 128 + i));
    end
    chk("t3_stable",     32'(stab_viol), 0);
    chk("t3_ovf_sticky", 32'(bus.overflow), 1);

    // Reset while the strobe is high with 3 entries queued
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      wr(2'b00, 8'(8'h10 + i));
    end
    chk("t4_pre_int",   32'(bus.gpu_int_en), 1);
    chk("t4_pre_count", 32'(bus.count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_int",      32'(bus.gpu_int_en), 0);
    chk("t4_empty",    32'(bus.empty), 1);
    chk("t4_count",    32'(bus.count), 0);
    chk("t4_busy",     32'(bus.busy), 0);
    chk("t4_overflow", 32'(bus.overflow), 0);
    repeat (10) tick();
    chk("t4_no_replay", 32'(cap_q.size()), 1);
    chk("t4_idle",      32'(bus.busy), 0);

`ifdef GPU_CMDQ_VSYNC_SWAP_EN
    // DISPLAY at head waits for vblank and blocks the entry behind it
    clear_mon();
    bus.vblank = 1'b0;
    wr(2'b00, 8'h11);
    wr(2'b10, 8'h5a);
    wr(2'b00, 8'h41);
    repeat (20) tick();
    chk("t5_blocked_pulses", 32'(cap_q.size()), 1);
    chk("t5_blocked_busy",   32'(bus.busy), 0);
    chk("t5_blocked_count",  32'(bus.count), 2);
    bus.vblank = 1'b1;
    wait_idle("t5_drain", 40);
    chk("t5_npulses", 32'(cap_q.size()), 3);
    if (cap_q.size() > 2) begin
      chk("t5_first",   32'(cap_q[0]), 'h011);
      chk("t5_display", 32'(cap_q[1]), 'h25a);
      chk("t5_store",   32'(cap_q[2]), 'h041);
    end
`else
    // Without the option, DISPLAY launches regardless of vblank
    clear_mon();
    bus.vblank = 1'b0;
    wr(2'b10, 8'h5a);
    wait_idle("t5_drain", 20);
    chk("t5_npulses", 32'(cap_q.size()), 1);
    if (cap_q.size() > 0) chk("t5_display", 32'(cap_q[0]), 'h25a);
    bus.vblank = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
